u_arb: RTL

U_ARB -- requirements
Module: u_arb

---
 rtl/u_arb_pkg.sv | 22 ++
 rtl/u_arb_u.sv | 41 ++++
 rtl/u_arb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/u_arb_pkg.sv
// rtl/u_arb_pkg.sv - shared types and constants for the u_arb unary-checker arbiter
//
// Contents:
//   id_width()   : width of a requester index for N requesters (minimum 1)
//   ID_W_DEFAULT : id width for the default N=4 build
//   STATS_W      : width of the optional admit/reject counters
//   slot_state_e : output slot states (EMPTY, FULL)
package u_arb_pkg;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEFAULT = id_width(4);
  localparam int STATS_W      = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/u_arb_u.sv
// rtl/u_arb_u.sv - combinational unary (thermometer) code checker
//
// A vector is unary when its set bits form one contiguous run starting at
// bit 0 (0...01...1, including all-zeros and all-ones). With
// P_ADMIT_COMPLIMENT_EN != 0 the bitwise complement of such a vector
// (1...10...0) is admitted as well.
//
// Ports:
//   i_x        in  W : candidate vector
//   o_is_unary out 1 : admission decision
module u #(
  parameter int W                     = 8,
  parameter int P_ADMIT_COMPLIMENT_EN = 0
) (
  input  logic [W-1:0] i_x,
  output logic         o_is_unary
);

  logic [W-1:0] w_inc;
  logic         w_thermo;

  // x & (x+1) clears the lowest run of ones; zero means that run was all of x.
  assign w_inc    = i_x + W'(1);
  assign w_thermo = ((i_x & w_inc) == '0);

  generate
    if (P_ADMIT_COMPLIMENT_EN != 0) begin : g_compl
      logic [W-1:0] w_inv;
      logic [W-1:0] w_inv_inc;
      logic         w_thermo_inv;

      assign w_inv        = ~i_x;
      assign w_inv_inc    = w_inv + W'(1);
      assign w_thermo_inv = ((w_inv & w_inv_inc) == '0);
      assign o_is_unary   = w_thermo | w_thermo_inv;
    end else begin : g_plain
      assign o_is_unary = w_thermo;
    end
  endgenerate

endmodule

// File: rtl/u_arb.sv
// rtl/u_arb.sv - round-robin arbiter sharing one unary checker among N requesters
//
// Optional feature macro: U_ARB_STATS_EN (adds o_admit_cnt / o_reject_cnt).
//
// Ports:
//   clk            in  1       : clock, rising edge
//   arst_n         in  1       : asynchronous active-low reset
//   i_req_vld      in  N       : per-requester request valid
//   i_req_x        in  N x W   : per-requester candidate vector
//   o_req_rdy      out N       : per-requester accept, one-hot or zero
//   o_rsp_vld      out 1       : response valid
//   o_rsp_id       out clog2(N): requester index of the response
//   o_rsp_is_unary out 1       : checker decision for that requester's vector
//   i_rsp_rdy      in  1       : downstream accept
//   o_admit_cnt    out 16      : (U_ARB_STATS_EN) handshaked admits, saturating
//   o_reject_cnt   out 16      : (U_ARB_STATS_EN) handshaked rejects, saturating
module u_arb
  import u_arb_pkg::*;
#(
  parameter int W                     = 8,
  parameter int N                     = 4,
  parameter int P_ADMIT_COMPLIMENT_EN = 0,
  localparam int IW                   = id_width(N)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [N-1:0]        i_req_vld,
  input  logic [N-1:0][W-1:0] i_req_x,
  output logic [N-1:0]        o_req_rdy,
  output logic                o_rsp_vld,
  output logic [IW-1:0]       o_rsp_id,
  output logic                o_rsp_is_unary,
  input  logic                i_rsp_rdy
`ifdef U_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]  o_admit_cnt,
  output logic [STATS_W-1:0]  o_reject_cnt
`endif
);

  slot_state_e   r_state;
  slot_state_e   w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_rsp_id;
  logic          r_rsp_is_unary;

  logic          w_gnt_vld;
  logic [IW-1:0] w_gnt_idx;
  logic [IW-1:0] w_ptr_nxt;
  logic          w_slot_free;
  logic          w_xfer;
  logic [W-1:0]  w_chk_x;
  logic          w_chk_is_unary;
  logic [N-1:0]  w_req_rdy;

  // Round-robin pick: the second pass (indices >= ptr) overrides the first
  // (indices < ptr), and descending order leaves the lowest hit in each pass.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req_vld[i] && (i < int'(r_ptr))) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req_vld[i] && (i >= int'(r_ptr))) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IW'(i);
      end
    end
  end

  // Only the granted vector reaches the shared checker; idle cycles see zero.
  assign w_chk_x = w_gnt_vld ? i_req_x[w_gnt_idx] : '0;

  u #(
    .W                    (W),
    .P_ADMIT_COMPLIMENT_EN(P_ADMIT_COMPLIMENT_EN)
  ) u_chk (
    .i_x       (w_chk_x),
    .o_is_unary(w_chk_is_unary)
  );

  // arst_n gates the accept so nothing is offered while reset is held.
  assign w_xfer = w_gnt_vld & w_slot_free & arst_n;

  always_comb begin
    w_req_rdy = '0;
    if (w_xfer) begin
      w_req_rdy[w_gnt_idx] = 1'b1;
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == IW'(N - 1)) ? '0 : (w_gnt_idx + IW'(1));

  // Output slot FSM: a full slot can accept new data in the same cycle it drains.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_free = 1'b0;
    unique case (r_state)
      EMPTY: begin
        w_slot_free = 1'b1;
        if (w_xfer) begin
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        w_slot_free = i_rsp_rdy;
        if (w_xfer) begin
          w_state_nxt = FULL;
        end else if (i_rsp_rdy) begin
          w_state_nxt = EMPTY;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ptr          <= '0;
      r_rsp_id       <= '0;
      r_rsp_is_unary <= 1'b0;
    end else if (w_xfer) begin
      r_ptr          <= w_ptr_nxt;
      r_rsp_id       <= w_gnt_idx;
      r_rsp_is_unary <= w_chk_is_unary;
    end
  end

  assign o_req_rdy      = w_req_rdy;
  assign o_rsp_vld      = (r_state == FULL);
  assign o_rsp_id       = r_rsp_id;
  assign o_rsp_is_unary = r_rsp_is_unary;

`ifdef U_ARB_STATS_EN
  logic                r_hs_unused;
  logic [STATS_W-1:0]  r_admit_cnt;
  logic [STATS_W-1:0]  r_reject_cnt;
  logic                w_hs;

  assign w_hs = o_rsp_vld & i_rsp_rdy;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_admit_cnt  <= '0;
      r_reject_cnt <= '0;
      r_hs_unused  <= 1'b0;
    end else begin
      r_hs_unused <= 1'b0;
      if (w_hs && r_rsp_is_unary && (r_admit_cnt != '1)) begin
        r_admit_cnt <= r_admit_cnt + STATS_W'(1);
      end
      if (w_hs && !r_rsp_is_unary && (r_reject_cnt != '1)) begin
        r_reject_cnt <= r_reject_cnt + STATS_W'(1);
      end
    end
  end

  assign o_admit_cnt  = r_admit_cnt;
  assign o_reject_cnt = r_reject_cnt;
`endif

endmodule
